// File: rtl/serial_cmd_ctrl.sv
// Serial command sequencer: builds 5-byte frames, executes the command, returns a 4-byte reply.
// Latency: EXEC one cycle after the 5th byte; first tx_start two cycles after the 5th rx_valid.
// Backpressure: reply bytes wait on tx_ready; frames finishing mid-reply are dropped and flag overrun.
module serial_cmd_ctrl #(
    parameter logic [31:0] COUNT_INIT = 32'd260,
    parameter int unsigned RX_TIMEOUT = 100000,
    parameter logic [31:0] CONST_WORD = 32'h01010101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        wr_req,
    output logic        rd_req,
    input  logic [31:0] ram_rdata,
    input  logic        ram_rd_valid,
    output logic        overrun
);

    localparam logic [7:0] CMD_ADDR     = 8'h01;
    localparam logic [7:0] CMD_LOAD     = 8'h02;
    localparam logic [7:0] CMD_WRITE    = 8'h03;
    localparam logic [7:0] CMD_READ_REQ = 8'h04;
    localparam logic [7:0] CMD_READ     = 8'h05;
    localparam logic [7:0] CMD_COUNT    = 8'h06;
    localparam logic [7:0] CMD_CONST    = 8'h07;

    // Last idle-cycle index before a partial frame is thrown away.
    localparam logic [31:0] TMO_LAST = (RX_TIMEOUT == 0) ? 32'd0 : 32'(RX_TIMEOUT - 1);
    localparam bit          TMO_ON   = (RX_TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_TX_LOAD,
        S_TX_BUSY,
        S_TX_DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [39:0] shift_q;
    logic [2:0]  byte_cnt;
    logic [31:0] tmo_cnt;
    logic        frame_done;

    logic [31:0] resp_q;
    logic [31:0] exec_resp;
    logic [2:0]  bytes_left;
    logic [31:0] count_q;
    logic [31:0] rd_q;

    logic [7:0]  cmd;
    logic [31:0] data;

    // The frame is read straight from the shift register during EXEC; a new
    // byte can only shift it at the end of that cycle, so no extra copy is needed.
    assign cmd        = shift_q[39:32];
    assign data       = shift_q[31:0];
    assign frame_done = rx_valid && (byte_cnt == 3'd4);
    assign tx_data    = resp_q[31:24];

    // Frame assembly: shift bytes in, count to five, drop stale partial frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
        end else if (rx_valid) begin
            shift_q  <= {shift_q[31:0], rx_data};
            byte_cnt <= frame_done ? 3'd0 : byte_cnt + 3'd1;
            tmo_cnt  <= '0;
        end else if (TMO_ON && (byte_cnt != 3'd0)) begin
            if (tmo_cnt >= TMO_LAST) begin
                byte_cnt <= '0;
                tmo_cnt  <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe outputs; strobes decode from state so reset kills them at once.
    always_comb begin
        state_d  = state_q;
        tx_start = 1'b0;
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_done) state_d = S_EXEC;
            end
            S_EXEC: begin
                wr_req  = (cmd == CMD_WRITE);
                rd_req  = (cmd == CMD_READ_REQ);
                state_d = S_TX_LOAD;
            end
            S_TX_LOAD: begin
                if (tx_ready) begin
                    tx_start = 1'b1;
                    state_d  = S_TX_BUSY;
                end
            end
            S_TX_BUSY: begin
                // uart_tx may hold ready high for a couple of cycles after start.
                if (!tx_ready) state_d = S_TX_DONE;
            end
            S_TX_DONE: begin
                if (tx_ready) state_d = (bytes_left == 3'd1) ? S_IDLE : S_TX_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Response word for the command currently in EXEC.
    always_comb begin
        exec_resp = 32'hFFFF_FFFF;
        case (cmd)
            CMD_ADDR:     exec_resp = data;
            CMD_LOAD:     exec_resp = data;
            CMD_WRITE:    exec_resp = 32'h0000_0003;
            CMD_READ_REQ: exec_resp = 32'h0000_0004;
            CMD_READ:     exec_resp = ram_rd_valid ? ram_rdata : rd_q;
            CMD_COUNT:    exec_resp = count_q;
            CMD_CONST:    exec_resp = CONST_WORD;
            default:      exec_resp = 32'hFFFF_FFFF;
        endcase
    end

    // Command side effects, reply shifting, read capture and overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_q     <= '0;
            bytes_left <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            count_q    <= COUNT_INIT;
            rd_q       <= '0;
            overrun    <= 1'b0;
        end else begin
            if (ram_rd_valid) rd_q <= ram_rdata;
            if (frame_done && (state_q != S_IDLE)) overrun <= 1'b1;
            case (state_q)
                S_EXEC: begin
                    resp_q     <= exec_resp;
                    bytes_left <= 3'd4;
                    case (cmd)
                        CMD_ADDR:  ram_addr  <= data;
                        CMD_LOAD:  ram_wdata <= data;
                        CMD_COUNT: count_q   <= count_q + 32'd1;
                        default:   ;
                    endcase
                end
                S_TX_DONE: begin
                    if (tx_ready) begin
                        resp_q     <= {resp_q[23:0], 8'h00};
                        bytes_left <= bytes_left - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_cmd_ctrl.sv
// Testbench for serial_cmd_ctrl: random and directed frames against a command-level model.
// Latency: responses collected from a uart_tx model that drops ready 2 cycles after start, busy 10.
// Backpressure: the uart_tx model holds tx_ready low while it is busy with a byte.
module tb_serial_cmd_ctrl;

    localparam logic [31:0] CONST_W = 32'h01010101;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        wr_req;
    logic        rd_req;
    logic [31:0] ram_rdata;
    logic        ram_rd_valid;
    logic        overrun;

    serial_cmd_ctrl #(
        .COUNT_INIT (32'd260),
        .RX_TIMEOUT (20),
        .CONST_WORD (CONST_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .ram_rdata    (ram_rdata),
        .ram_rd_valid (ram_rd_valid),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_rx_cyc = 0;
    int wr_cycles = 0;
    int rd_cycles = 0;

    logic [7:0] got[$];
    int         got_cyc[$];

    // Reference state, at the level of the command set.
    logic [31:0] m_addr, m_wdata, m_count, m_rd;
    int          wr_exp, rd_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_exec(input logic [7:0] c, input logic [31:0] d);
        logic [31:0] r;
        case (c)
            8'h01: begin m_addr = d; r = d; end
            8'h02: begin m_wdata = d; r = d; end
            8'h03: begin wr_exp++; r = 32'd3; end
            8'h04: begin rd_exp++; r = 32'd4; end
            8'h05: r = m_rd;
            8'h06: begin r = m_count; m_count = m_count + 1; end
            8'h07: r = CONST_W;
            default: r = 32'hFFFFFFFF;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_addr = 0; m_wdata = 0; m_count = 260; m_rd = 0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx stand-in: capture each started byte, then go busy.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                check("start_while_ready", tx_ready, 1'b1);
                got.push_back(tx_data);
                got_cyc.push_back(cyc);
                @(negedge clk);
                check("tx_start_one_cycle", tx_start, 1'b0);
                @(negedge clk);
                tx_ready = 1'b0;
                repeat (10) @(negedge clk);
                tx_ready = 1'b1;
            end
        end
    end

    // Request pulse width accounting.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_req) wr_cycles++;
            if (rd_req) rd_cycles++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        last_rx_cyc = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] d, input int maxgap);
        logic [31:0] w;
        w = d;
        send_byte(c, $urandom_range(0, maxgap));
        for (int i = 0; i < 3; i++) begin
            send_byte(w[31:24], $urandom_range(0, maxgap));
            w = w << 8;
        end
        send_byte(w[31:24], 0);
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] exp, input bit chk_lat);
        int t;
        logic [31:0] word;
        int first_cyc;
        t = 0;
        while (got.size() < 4 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_nbytes"}, got.size(), 4);
        word = 0;
        first_cyc = (got_cyc.size() > 0) ? got_cyc[0] : 0;
        for (int i = 0; i < 4; i++) begin
            if (got.size() > 0) begin
                word = {word[23:0], got.pop_front()};
                void'(got_cyc.pop_front());
            end
        end
        check(tag, word, exp);
        if (chk_lat) check({tag, "_latency"}, 32'((first_cyc - last_rx_cyc) >= 2), 1);
        repeat (16) @(negedge clk);
        check({tag, "_addr"}, ram_addr, m_addr);
        check({tag, "_wdata"}, ram_wdata, m_wdata);
        check({tag, "_wr_pulses"}, wr_cycles, wr_exp);
        check({tag, "_rd_pulses"}, rd_cycles, rd_exp);
    endtask

    task automatic rd_pulse(input logic [31:0] v);
        @(negedge clk);
        ram_rd_valid = 1'b1;
        ram_rdata    = v;
        m_rd         = v;
        @(negedge clk);
        ram_rd_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] c, input logic [31:0] d);
        logic [31:0] r;
        send_frame(c, d, 3);
        r = model_exec(c, d);
        expect_resp(tag, r, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  c;
        int          t;

        reset = 1'b1; rx_valid = 0; rx_data = 0; ram_rdata = 0; ram_rd_valid = 0;
        wr_exp = 0; rd_exp = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_wr_req", wr_req, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // COUNT twice from reset.
        run_frame("count0", 8'h06, 32'h0);
        run_frame("count1", 8'h06, 32'h0);

        // Address, data, write.
        run_frame("addr", 8'h01, 32'h00001000);
        run_frame("load", 8'h02, 32'hDEADBEEF);
        run_frame("write", 8'h03, 32'h0);

        // Read request, returned data, read back.
        run_frame("read_req", 8'h04, 32'h0);
        rd_pulse(32'h12345678);
        run_frame("read", 8'h05, 32'h0);

        // Read data arriving in the same cycle the READ executes.
        send_frame(8'h05, 32'h0, 2);
        ram_rd_valid = 1'b1;
        ram_rdata    = 32'hCAFEF00D;
        m_rd         = 32'hCAFEF00D;
        @(negedge clk);
        ram_rd_valid = 1'b0;
        expect_resp("read_same_cycle", model_exec(8'h05, 0), 1'b1);

        // Partial frame timed out, then CONST; unknown command.
        send_byte(8'h11, 0);
        send_byte(8'h22, 25);
        run_frame("const_after_tmo", 8'h07, 32'h0);
        check("tmo_no_extra", got.size(), 0);
        run_frame("unknown", 8'hAA, 32'h12345678);

        // Randomized command mix.
        for (int i = 0; i < 24; i++) begin
            t = $urandom_range(0, 8);
            c = (t <= 6) ? 8'(t + 1) : (8'h80 | 8'($urandom));
            v = $urandom;
            run_frame("rand", c, v);
            if (c == 8'h04) rd_pulse($urandom);
        end
        check("overrun_clear", overrun, 0);

        // Second frame completes while the first reply is in flight.
        send_frame(8'h07, 32'h0, 1);
        t = 0;
        while (got.size() < 1 && t < 500) begin @(negedge clk); t++; end
        send_frame(8'h06, 32'h0, 0);
        expect_resp("overrun_first", CONST_W, 1'b0);
        repeat (100) @(negedge clk);
        check("overrun_no_resp", got.size(), 0);
        check("overrun_flag", overrun, 1);

        // Reset during the second reply byte.
        send_frame(8'h06, 32'h0, 1);
        t = 0;
        while (got.size() < 1 && t < 500) begin @(negedge clk); t++; end
        t = 0;
        @(posedge clk); #2;
        while (!tx_start && t < 500) begin @(posedge clk); #2; t++; end
        check("byte2_started", tx_start, 1);
        reset = 1'b1;
        #1;
        check("async_tx_start", tx_start, 0);
        check("reset_overrun", overrun, 0);
        check("reset_addr", ram_addr, 0);
        check("reset_wdata", ram_wdata, 0);
        got.delete();
        got_cyc.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        got.delete();
        got_cyc.delete();
        run_frame("count_after_reset", 8'h06, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
